// File: rtl/load_store_unit_if.sv
// Memory-stage bus of the load/store unit: pipeline operation in, data-memory strobes and load result out.
// The slave modport is the unit; the master modport is the pipeline/memory environment.
interface load_store_unit_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
);
    logic               i_valid;
    logic               i_mem_read;
    logic               i_mem_write;
    logic [1:0]         i_size;
    logic               i_unsigned;
    logic [NB_ADDR-1:0] i_address;
    logic [NB_DATA-1:0] i_store_data;
    logic [NB_DATA-1:0] i_mem_data;
    logic               o_mem_read_enable;
    logic               o_mem_write_enable;
    logic [NB_ADDR-1:0] o_mem_read_address;
    logic [NB_ADDR-1:0] o_mem_write_address;
    logic [NB_DATA-1:0] o_mem_data;
    logic [NB_DATA-1:0] o_load_data;
    logic               o_load_valid;
    logic               o_stall;
    logic               o_fault;

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_size, i_unsigned,
               i_address, i_store_data, i_mem_data,
        output o_mem_read_enable, o_mem_write_enable, o_mem_read_address,
               o_mem_write_address, o_mem_data, o_load_data, o_load_valid,
               o_stall, o_fault
    );

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_size, i_unsigned,
               i_address, i_store_data, i_mem_data,
        input  o_mem_read_enable, o_mem_write_enable, o_mem_read_address,
               o_mem_write_address, o_mem_data, o_load_data, o_load_valid,
               o_stall, o_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: word-addressed data memory access with byte/half loads (sign/zero extended)
// and byte/half stores done as a two-cycle read-modify-write.
module load_store_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    load_store_unit_if.slave     bus
);
    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t             r_state, w_next_state;
    logic [NB_DATA-1:0] r_load_data, r_rmw_data;
    logic [NB_ADDR-1:0] r_rmw_addr;
    logic               r_load_valid, r_fault;

    logic [NB_ADDR-1:0] w_word_idx;
    logic [1:0]         w_lane;
    logic               w_access, w_misaligned, w_illegal;
    logic               w_load, w_store_word, w_store_part;
    logic               w_rd_en, w_wr_en, w_stall;
    logic [NB_ADDR-1:0] w_rd_addr, w_wr_addr;
    logic [NB_DATA-1:0] w_wr_data;

    function automatic logic [NB_DATA-1:0] f_extend(input logic [NB_DATA-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic uns);
        logic [NB_DATA-1:0] shifted;
        logic [NB_DATA-1:0] res;
        shifted = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{(NB_DATA-8){~uns & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{(NB_DATA-16){~uns & shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [NB_DATA-1:0] f_merge(input logic [NB_DATA-1:0] old_word,
                                                   input logic [NB_DATA-1:0] store,
                                                   input logic [1:0] lane,
                                                   input logic [1:0] size);
        logic [NB_DATA-1:0] mask;
        mask = (size == 2'b00) ? NB_DATA'(8'hFF) : NB_DATA'(16'hFFFF);
        return (old_word & ~(mask << {lane, 3'b000})) | ((store & mask) << {lane, 3'b000});
    endfunction

    assign w_word_idx = {2'b00, bus.i_address[NB_ADDR-1:2]};
    assign w_lane     = bus.i_address[1:0];

    always_comb begin
        w_misaligned = 1'b1;
        case (bus.i_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = w_lane[0];
            2'b10:   w_misaligned = (w_lane != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_access     = !i_reset && (r_state == IDLE) && bus.i_valid
                          && (bus.i_mem_read || bus.i_mem_write);
    assign w_illegal    = w_access && (w_misaligned || (bus.i_mem_read && bus.i_mem_write));
    assign w_load       = w_access && !w_illegal && bus.i_mem_read;
    assign w_store_word = w_access && !w_illegal && bus.i_mem_write && (bus.i_size == 2'b10);
    // Sub-word stores need the current word first, so they take the read port and stall.
    assign w_store_part = w_access && !w_illegal && bus.i_mem_write && (bus.i_size != 2'b10);

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_stall      = 1'b0;
        w_rd_addr    = '0;
        w_wr_addr    = '0;
        w_wr_data    = '0;
        if (!i_reset) begin
            case (r_state)
                IDLE: begin
                    if (w_load || w_store_part) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_word_idx;
                    end
                    if (w_store_word) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_word_idx;
                        w_wr_data = bus.i_store_data;
                    end
                    if (w_store_part) begin
                        w_stall      = 1'b1;
                        w_next_state = RMW_WRITE;
                    end
                end
                RMW_WRITE: begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = r_rmw_addr;
                    w_wr_data    = r_rmw_data;
                    w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_rmw_addr   <= '0;
            r_rmw_data   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_load_valid <= w_load;
            r_fault      <= w_illegal;
            if (w_load)
                r_load_data <= f_extend(bus.i_mem_data, w_lane, bus.i_size, bus.i_unsigned);
            if (w_store_part) begin
                r_rmw_addr <= w_word_idx;
                r_rmw_data <= f_merge(bus.i_mem_data, bus.i_store_data, w_lane, bus.i_size);
            end
        end
    end

    assign bus.o_mem_read_enable   = w_rd_en;
    assign bus.o_mem_read_address  = w_rd_addr;
    assign bus.o_mem_write_enable  = w_wr_en;
    assign bus.o_mem_write_address = w_wr_addr;
    assign bus.o_mem_data          = w_wr_data;
    assign bus.o_stall             = w_stall;
    assign bus.o_load_data         = r_load_data;
    assign bus.o_load_valid        = r_load_valid;
    assign bus.o_fault             = r_fault;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, expected loads/faults/writes queued at issue
// and consumed by a monitor whenever the unit presents them.
module tb_load_store_unit;
    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    load_store_unit_if #(.NB_DATA(32), .NB_ADDR(32)) bus ();

    load_store_unit #(.NB_DATA(32), .NB_ADDR(32)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int          kind;
        logic [31:0] idx;
        logic [31:0] data;
    } exp_t;

    exp_t        q_resp[$];
    exp_t        q_wr[$];
    logic [31:0] mem [64];
    logic [7:0]  ref_b [256];
    int          n_total = 0;
    int          n_pass  = 0;
    int          fault_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] last_load = '0;

    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    assign bus.i_mem_data = mem[bus.o_mem_read_address[5:0]];

    always @(posedge i_clock) begin
        if (bd_en)
            mem[bd_idx] <= bd_data;
        else if (bus.o_mem_write_enable)
            mem[bus.o_mem_write_address[5:0]] <= bus.o_mem_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
    endfunction

    // Monitor: every unit-side event consumes the oldest matching expectation.
    always @(negedge i_clock) begin
        exp_t e;
        if (!i_reset) begin
            if (bus.o_stall) stall_cnt++;
            chk("load_valid_and_fault", {31'b0, bus.o_load_valid & bus.o_fault}, 32'h0);
            if (!bus.o_mem_read_enable) chk("rd_addr_when_idle", bus.o_mem_read_address, 32'h0);
            if (!bus.o_mem_write_enable) begin
                chk("wr_addr_when_idle", bus.o_mem_write_address, 32'h0);
                chk("wr_data_when_idle", bus.o_mem_data, 32'h0);
            end
            if (bus.o_load_valid) begin
                last_load = bus.o_load_data;
                if (q_resp.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_load: got %h required none", bus.o_load_data);
                end else begin
                    e = q_resp.pop_front();
                    chk("resp_kind_load", 32'(e.kind), 32'd0);
                    chk("load_data", bus.o_load_data, e.data);
                end
            end
            if (bus.o_fault) begin
                fault_cnt++;
                if (q_resp.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_fault: got 1 required 0");
                end else begin
                    e = q_resp.pop_front();
                    chk("resp_kind_fault", 32'(e.kind), 32'd1);
                end
            end
            if (bus.o_mem_write_enable) begin
                if (q_wr.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got idx %h data %h required none",
                             bus.o_mem_write_address, bus.o_mem_data);
                end else begin
                    e = q_wr.pop_front();
                    chk("write_idx", bus.o_mem_write_address, e.idx);
                    chk("write_data", bus.o_mem_data, e.data);
                end
            end
        end
    end

    task automatic set_word(input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ref_b[idx*4+k] = w[8*k +: 8];
        bd_en = 1'b1; bd_idx = 6'(idx); bd_data = w;
        @(posedge i_clock); #1;
        bd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    // Issue one operation at posedge+1; returns at posedge+1 once the unit is ready for the next.
    task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data, input bit abort);
        int          n, a, idx;
        bit          legal, part, wword;
        logic [31:0] ev;
        exp_t        e;
        n     = 1 << sz;
        a     = int'(addr);
        idx   = a / 4;
        legal = (rd || wr) && (sz != 2'b11) && (a % n == 0) && !(rd && wr);
        part  = legal && wr && (sz != 2'b10);
        wword = legal && wr && (sz == 2'b10);
        bus.i_valid = 1'b1; bus.i_mem_read = rd; bus.i_mem_write = wr; bus.i_size = sz;
        bus.i_unsigned = uns; bus.i_address = addr; bus.i_store_data = data;
        if ((rd || wr) && !legal) begin
            e.kind = 1; e.idx = '0; e.data = '0; q_resp.push_back(e);
        end
        if (legal && rd) begin
            ev = '0;
            for (int k = 0; k < n; k++) ev |= 32'(ref_b[a+k]) << (8*k);
            if (!uns && n < 4 && ev[8*n-1]) ev |= ~((32'h1 << (8*n)) - 32'h1);
            e.kind = 0; e.idx = '0; e.data = ev; q_resp.push_back(e);
        end
        if (legal && wr && !abort) begin
            for (int k = 0; k < n; k++) ref_b[a+k] = data[8*k +: 8];
            e.kind = 2; e.idx = 32'(idx); e.data = ref_word(idx); q_wr.push_back(e);
        end
        @(negedge i_clock);
        chk("stall", {31'b0, bus.o_stall}, {31'b0, part});
        chk("read_enable", {31'b0, bus.o_mem_read_enable}, {31'b0, legal && (rd || part)});
        chk("write_enable", {31'b0, bus.o_mem_write_enable}, {31'b0, wword});
        if (legal && (rd || part)) chk("read_idx", bus.o_mem_read_address, 32'(idx));
        @(posedge i_clock); #1;
        if (part && abort) begin
            i_reset = 1'b1;
            @(negedge i_clock);
            chk("rst_write_enable", {31'b0, bus.o_mem_write_enable}, 32'h0);
            chk("rst_read_enable", {31'b0, bus.o_mem_read_enable}, 32'h0);
            chk("rst_stall", {31'b0, bus.o_stall}, 32'h0);
            chk("rst_mem_data", bus.o_mem_data, 32'h0);
            @(posedge i_clock); #1;
            i_reset = 1'b0;
            bus.i_valid = 1'b0;
            @(negedge i_clock);
            chk("abort_load_data", bus.o_load_data, 32'h0);
            chk("abort_load_valid", {31'b0, bus.o_load_valid}, 32'h0);
            chk("abort_fault", {31'b0, bus.o_fault}, 32'h0);
            chk("abort_mem_word", mem[idx], ref_word(idx));
            @(posedge i_clock); #1;
        end else if (part) begin
            bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
            bus.i_size = 2'($urandom_range(0, 3)); bus.i_address = $urandom_range(0, 255);
            @(negedge i_clock);
            chk("rmw_stall", {31'b0, bus.o_stall}, 32'h0);
            chk("rmw_read_enable", {31'b0, bus.o_mem_read_enable}, 32'h0);
            chk("rmw_write_enable", {31'b0, bus.o_mem_write_enable}, 32'h1);
            @(posedge i_clock); #1;
        end
        bus.i_valid = 1'b0; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
    endtask

    initial begin
        int f0, s0, w;
        bus.i_valid = 1'b1; bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b1;
        bus.i_size = 2'b01; bus.i_unsigned = 1'b0; bus.i_address = 32'h12; bus.i_store_data = 32'h55;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        bus.i_mem_write = 1'b0; bus.i_size = 2'b00;
        @(negedge i_clock);
        chk("reset_read_enable", {31'b0, bus.o_mem_read_enable}, 32'h0);
        chk("reset_write_enable", {31'b0, bus.o_mem_write_enable}, 32'h0);
        chk("reset_stall", {31'b0, bus.o_stall}, 32'h0);
        chk("reset_load_valid", {31'b0, bus.o_load_valid}, 32'h0);
        chk("reset_load_data", bus.o_load_data, 32'h0);
        chk("reset_fault", {31'b0, bus.o_fault}, 32'h0);
        @(posedge i_clock); #1;
        bus.i_valid = 1'b0; bus.i_mem_read = 1'b0;
        i_reset = 1'b0;
        idle(1);

        do_op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        idle(2);
        chk("word_roundtrip", last_load, 32'hDEADBEEF);

        set_word(4, 32'h11223344);
        do_op(0, 1, 2'b00, 0, 32'h12, 32'h000000AB, 0);
        idle(1);
        chk("byte_store_merge", mem[4], 32'h11AB3344);

        set_word(4, 32'h80FF7F01);
        do_op(1, 0, 2'b00, 0, 32'h11, 32'h0, 0);
        idle(2);
        chk("lb_0x11", last_load, 32'h0000007F);
        do_op(1, 0, 2'b00, 0, 32'h12, 32'h0, 0);
        idle(2);
        chk("lb_0x12", last_load, 32'hFFFFFFFF);
        do_op(1, 0, 2'b01, 1, 32'h12, 32'h0, 0);
        idle(2);
        chk("lhu_0x12", last_load, 32'h000080FF);

        f0 = fault_cnt;
        do_op(1, 0, 2'b01, 0, 32'h13, 32'h0, 0);
        do_op(1, 0, 2'b10, 0, 32'h16, 32'h0, 0);
        do_op(1, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        do_op(1, 1, 2'b10, 0, 32'h10, 32'h12345678, 0);
        idle(2);
        chk("fault_pulses", 32'(fault_cnt - f0), 32'd4);
        chk("fault_mem_unchanged", mem[4], 32'h80FF7F01);

        do_op(0, 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 1);
        do_op(1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
        idle(2);

        s0 = stall_cnt;
        do_op(0, 1, 2'b00, 0, 32'h31, 32'h0000005A, 0);
        do_op(1, 0, 2'b10, 0, 32'h30, 32'h0, 0);
        idle(2);
        chk("b2b_stall_cycles", 32'(stall_cnt - s0), 32'd1);
        chk("b2b_merged_load", last_load, ref_word(12));

        for (int i = 0; i < 300; i++) begin
            w = $urandom_range(0, 9);
            do_op(w < 5 || w == 9, w >= 5, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 255), $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        for (int t = 0; t < 10 && (q_resp.size() != 0 || q_wr.size() != 0); t++) idle(1);
        chk("resp_queue_drained", 32'(q_resp.size()), 32'd0);
        chk("write_queue_drained", 32'(q_wr.size()), 32'd0);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
